fifo18_to_gmii: RTL and testbench
=================================

FIFO18_TO_GMII -- requirements
Module: fifo18_to_gmii

Interface
REQ-001 Parameter Gap, default 4'hC: minimum idle (gmii_tx_en low) cycles between frames, legal 1..15.
REQ-002 Parameter StartLevel, default 8'h04: minimum FIFO occupancy (rd_count) required to start a frame.
REQ-003 gmii_tx_clk  in  1  sole clock; all logic on rising edge; synchronous reset, active-high.
REQ-004 sys_rst  in  1  synchronous reset, active-high, sampled on gmii_tx_clk.
REQ-005 tx_enable  in  1  level; permits starting new frames.
REQ-006 dout  in  18  FIFO read data, valid the cycle after rd_en; [17]=hi-byte valid, [16]=lo-byte valid, [15:8]=first byte, [7:0]=second byte.
REQ-007 empty  in  1  FIFO empty.
REQ-008 rd_count  in  8  FIFO occupancy in words.
REQ-009 rd_en  out  1  FIFO read strobe; one word per asserted cycle.
REQ-010 gmii_txd  out  8  GMII transmit byte, registered.
REQ-011 gmii_tx_en  out  1  GMII transmit enable, registered.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 tx_frame_count  out  32  frames transmitted to completion, wraps.
REQ-014 tx_underrun_count  out  16  frames aborted by underrun, wraps.
REQ-015 underrun  out  1  one-cycle pulse on each abort.

Function
REQ-016 States: IDLE, PREAMBLE, SFD, DATA_HI, DATA_LO, DISCARD, IFG.
REQ-017 IDLE->PREAMBLE when tx_enable=1, empty=0, rd_count>=StartLevel; gmii_tx_en rises within 2 cycles of condition.
REQ-018 PREAMBLE: exactly 7 cycles gmii_txd=8'h55, tx_en=1; SFD: 1 cycle gmii_txd=8'hD5, tx_en=1.
REQ-019 Payload bytes follow SFD with no bubble; per word, byte [15:8] then [7:0]; tx_en stays high through the last valid byte.
REQ-020 Word flags 2'b11: both bytes sent, frame continues; 2'b10: hi byte sent, frame ends after it; 2'b00 or 2'b01: no byte sent, frame ends (word is terminator only).
REQ-021 Terminator word consumed from FIFO; the next frame starts from the following word.
REQ-022 Block prepends no CRC and inserts none; dout bytes pass unmodified.
REQ-023 rd_en issued early enough that every needed word is present with no gap; rd_en never asserted when empty=1.
REQ-024 Underrun: a word is needed mid-frame and empty=1 -> tx_en low on the next byte slot, underrun pulses 1 cycle, tx_underrun_count+1, enter DISCARD.
REQ-025 DISCARD: read and drop words (rd_en only when empty=0) until a word with flags!=2'b11 consumed, then IFG; tx_en stays low.
REQ-026 IFG: tx_en low, gmii_txd=8'h00 for at least Gap cycles after last frame byte, then IDLE.
REQ-027 tx_frame_count increments once per normal frame end (REQ-020), not on abort; same cycle as last byte or within 1 cycle.
REQ-028 tx_enable deasserted mid-frame: current frame completes normally; no new frame starts.
REQ-029 Whenever tx_en=0, gmii_txd=8'h00.
REQ-030 Frame of zero payload bytes (terminator immediately after SFD): preamble+SFD sent, frame counted.

Reset
REQ-031 sys_rst=1 at any edge: next cycle state=IDLE, rd_en=0, gmii_tx_en=0, gmii_txd=8'h00, busy=0, underrun=0, both counters 0; mid-frame reset truncates frame without underrun count.
REQ-032 No rd_en while sys_rst=1; FIFO reset is external.

Verification
REQ-033 FIFO preloaded {2'b11,16'h0102},{2'b11,16'h0304},{2'b00,16'h0}, tx_enable=1 -> tx_en 12 cycles: 55x7, D5, 01,02,03,04; tx_frame_count=1.
REQ-034 Odd frame {2'b11,16'hAABB},{2'b10,16'hCC00} + padding to StartLevel -> bytes 55x7,D5,AA,BB,CC; tx_en low after CC.
REQ-035 Two back-to-back frames queued -> tx_en low exactly >=12 cycles between them, second frame intact, count=2.
REQ-036 FIFO drains mid-frame (no terminator yet) -> tx_en drops, underrun pulse, tx_underrun_count=1; later words up to terminator discarded, next frame clean.
REQ-037 sys_rst asserted during payload -> next cycle tx_en=0, counters 0, busy=0; fresh frame after release transmits correctly.
REQ-038 rd_count=3 with StartLevel=4 -> no transmission; fourth word written -> frame starts within 2 cycles.

Source files
------------

// File: rtl/fifo18_to_gmii_if.sv
// FIFO read port and GMII transmit bus seen by the frame serializer.
interface fifo18_to_gmii_if;
  logic [17:0] dout;
  logic        empty;
  logic [7:0]  rd_count;
  logic        rd_en;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;

  modport master (input dout, empty, rd_count, output rd_en, gmii_txd, gmii_tx_en);
  modport slave  (output dout, empty, rd_count, input rd_en, gmii_txd, gmii_tx_en);
endinterface

// File: rtl/fifo18_to_gmii.sv
// Serializes flagged 18-bit FIFO words into GMII frames: preamble, SFD, payload,
// with underrun abort/discard and a programmable inter-frame gap.
module fifo18_to_gmii #(
  parameter logic [3:0] Gap        = 4'hC,
  parameter logic [7:0] StartLevel = 8'h04
) (
  input  logic             gmii_tx_clk,
  input  logic             sys_rst,
  input  logic             tx_enable,
  fifo18_to_gmii_if.master bus,
  output logic             busy,
  output logic [31:0]      tx_frame_count,
  output logic [15:0]      tx_underrun_count,
  output logic             underrun
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA_HI, DATA_LO, DISCARD, IFG} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] txd, lo_byte;
  logic       tx_en, rd_req, vld, last, starve;
  logic [1:0] flags;
  logic       start_ok;

  assign flags          = bus.dout[17:16];
  assign start_ok       = tx_enable && !bus.empty && (bus.rd_count >= StartLevel);
  assign bus.rd_en      = rd_req && !sys_rst;
  assign bus.gmii_txd   = txd;
  assign bus.gmii_tx_en = tx_en;
  assign busy           = (state != IDLE);

  // A word is requested one byte-slot ahead so it lands on dout exactly when the
  // SFD / low-byte slot ends; starve remembers that the request could not be made.
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      txd               <= 8'h00;
      lo_byte           <= 8'h00;
      tx_en             <= 1'b0;
      rd_req            <= 1'b0;
      vld               <= 1'b0;
      last              <= 1'b0;
      starve            <= 1'b0;
      underrun          <= 1'b0;
      tx_frame_count    <= 32'd0;
      tx_underrun_count <= 16'd0;
    end else begin
      rd_req   <= 1'b0;
      underrun <= 1'b0;
      vld      <= bus.rd_en;
      case (state)
        IDLE: if (start_ok) begin
          state  <= PREAMBLE;
          cnt    <= 4'd0;
          tx_en  <= 1'b1;
          txd    <= 8'h55;
          starve <= 1'b0;
        end
        PREAMBLE: begin
          if (cnt == 4'd5) begin
            rd_req <= !bus.empty;
            starve <= bus.empty;
          end
          if (cnt == 4'd6) begin
            state <= SFD;
            txd   <= 8'hD5;
          end
          cnt <= cnt + 4'd1;
        end
        SFD, DATA_LO: begin
          if (starve) begin
            state             <= DISCARD;
            tx_en             <= 1'b0;
            txd               <= 8'h00;
            underrun          <= 1'b1;
            tx_underrun_count <= tx_underrun_count + 16'd1;
            rd_req            <= !bus.empty;
          end else if (flags[1]) begin
            state   <= DATA_HI;
            txd     <= bus.dout[15:8];
            lo_byte <= bus.dout[7:0];
            last    <= !flags[0];
            rd_req  <= flags[0] && !bus.empty;
            starve  <= flags[0] && bus.empty;
          end else begin
            state          <= IFG;
            cnt            <= 4'd0;
            tx_en          <= 1'b0;
            txd            <= 8'h00;
            tx_frame_count <= tx_frame_count + 32'd1;
          end
        end
        DATA_HI: begin
          if (last) begin
            state          <= IFG;
            cnt            <= 4'd0;
            tx_en          <= 1'b0;
            txd            <= 8'h00;
            tx_frame_count <= tx_frame_count + 32'd1;
          end else begin
            state <= DATA_LO;
            txd   <= lo_byte;
          end
        end
        // Reads alternate with data cycles so empty is never stale when sampled.
        DISCARD: begin
          if (vld && flags != 2'b11) begin
            state <= IFG;
            cnt   <= 4'd0;
          end else begin
            rd_req <= !rd_req && !bus.empty;
          end
        end
        IFG: begin
          if (cnt == Gap - 4'd1) state <= IDLE;
          else cnt <= cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo18_to_gmii.sv
// Scoreboard bench: stimulus parses pushed FIFO words into expected GMII byte
// streams; a negedge monitor pops and compares whatever the DUT transmits.
module tb_fifo18_to_gmii;
  localparam int GAP = 12;

  logic        gmii_tx_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tx_enable = 1'b0;
  logic        busy, underrun;
  logic [31:0] tx_frame_count;
  logic [15:0] tx_underrun_count;

  fifo18_to_gmii_if bus();

  fifo18_to_gmii dut (
    .gmii_tx_clk(gmii_tx_clk), .sys_rst(sys_rst), .tx_enable(tx_enable), .bus(bus),
    .busy(busy), .tx_frame_count(tx_frame_count), .tx_underrun_count(tx_underrun_count),
    .underrun(underrun)
  );

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  int          tests = 0, fails = 0;
  logic [17:0] fifo_q[$];
  logic [17:0] pend[$];
  int          exp_q[$];
  int          exp_frames = 0, exp_unders = 0, pulses = 0, starts = 0;
  bit          discarding = 1'b0;

  task automatic chk(input string name, input longint act, input longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Expected wire image of one frame: 7x55, D5, then the bytes each word's flags allow.
  task automatic emit(input bit aborted);
    logic [17:0] w;
    repeat (7) exp_q.push_back(32'h55);
    exp_q.push_back(32'hD5);
    foreach (pend[i]) begin
      w = pend[i];
      if (w[17]) begin
        exp_q.push_back(int'(w[15:8]));
        if (w[16]) exp_q.push_back(int'(w[7:0]));
      end
    end
    exp_q.push_back(-1);
    pend.delete();
    if (aborted) begin
      exp_unders++;
      discarding = 1'b1;
    end else begin
      exp_frames++;
    end
  endtask

  task automatic push_word(input logic [17:0] w);
    fifo_q.push_back(w);
    if (discarding) begin
      if (w[17:16] != 2'b11) discarding = 1'b0;
    end else begin
      pend.push_back(w);
      if (w[17:16] != 2'b11) emit(1'b0);
    end
  endtask

  task automatic push_frame4();
    for (int i = 0; i < 3; i++) push_word({2'b11, 16'($urandom)});
    push_word({2'b00, 16'($urandom)});
  endtask

  task automatic gen_frame(input bit last_one);
    int nd, kind;
    nd   = last_one ? $urandom_range(3, 6) : $urandom_range(0, 6);
    kind = $urandom_range(0, 2);
    for (int i = 0; i < nd; i++) push_word({2'b11, 16'($urandom)});
    push_word({(kind == 0) ? 2'b10 : (kind == 1) ? 2'b00 : 2'b01, 16'($urandom)});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge gmii_tx_clk); #1;
      n++;
    end
    chk({name, "_timeout"}, longint'(n < 3000), 1);
    chk({name, "_frames"}, tx_frame_count, exp_frames);
    chk({name, "_underruns"}, tx_underrun_count, exp_unders);
    chk({name, "_pulses"}, pulses, exp_unders);
  endtask

  // FIFO model: one-cycle read latency, flags visible on the following negedge.
  always @(posedge gmii_tx_clk) begin
    if (bus.rd_en) begin
      chk("rd_en_while_empty", longint'(fifo_q.size() == 0), 0);
      if (fifo_q.size() != 0) bus.dout <= fifo_q.pop_front();
    end
  end

  always @(negedge gmii_tx_clk) begin
    bus.empty    = (fifo_q.size() == 0);
    bus.rd_count = 8'(fifo_q.size());
  end

  bit prev_en = 1'b0, had = 1'b0;
  int idle = 0, mon_e;

  always @(negedge gmii_tx_clk) begin
    if (sys_rst) begin
      prev_en = 1'b0;
      had     = 1'b0;
      idle    = 0;
      pulses  = 0;
    end else begin
      if (bus.gmii_tx_en) begin
        if (!prev_en) begin
          starts++;
          if (had) chk("ifg_min", longint'(idle >= GAP), 1);
        end
        mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : -3;
        chk("tx_byte", bus.gmii_txd, mon_e);
        idle = 0;
      end else begin
        chk("idle_txd_zero", bus.gmii_txd, 0);
        if (prev_en) begin
          mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : -3;
          chk("frame_end", mon_e, -1);
          had = 1'b1;
        end
        idle++;
      end
      if (underrun) pulses++;
      prev_en = bus.gmii_tx_en;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nf, base;
    longint fc0;
    repeat (3) @(posedge gmii_tx_clk);
    #1;
    chk("rst_tx_en", bus.gmii_tx_en, 0);
    chk("rst_txd", bus.gmii_txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_frames", tx_frame_count, 0);
    chk("rst_unders", tx_underrun_count, 0);
    sys_rst = 1'b0;
    @(posedge gmii_tx_clk); #1;

    // Basic frame, zero-payload frame, then a padding frame.
    tx_enable = 1'b1;
    push_word({2'b11, 16'h0102});
    push_word({2'b11, 16'h0304});
    push_word({2'b00, 16'h0000});
    push_word({2'b01, 16'h1234});
    push_word({2'b11, 16'h5566});
    push_word({2'b11, 16'h7788});
    push_word({2'b11, 16'h99AA});
    push_word({2'b00, 16'hFFFF});
    wait_idle("basic");

    // Odd-length frame ending on a hi-only word.
    push_word({2'b11, 16'hAABB});
    push_word({2'b10, 16'hCC00});
    push_word({2'b11, 16'h1357});
    push_word({2'b11, 16'h2468});
    push_word({2'b11, 16'hACE0});
    push_word({2'b01, 16'h0000});
    wait_idle("odd");

    // Below start level: nothing happens until the fourth word arrives.
    base = starts;
    for (int i = 0; i < 3; i++) push_word({2'b11, 16'($urandom)});
    repeat (30) @(posedge gmii_tx_clk);
    #1;
    chk("below_level_starts", starts - base, 0);
    chk("below_level_busy", busy, 0);
    push_word({2'b00, 16'h0000});
    n = 0;
    while (!bus.gmii_tx_en && n < 4) begin
      @(posedge gmii_tx_clk); #1;
      n++;
    end
    chk("level_start_latency", longint'(n <= 2 && bus.gmii_tx_en), 1);
    wait_idle("level");

    // Underrun: four continuing words then the FIFO runs dry.
    for (int i = 0; i < 4; i++) push_word({2'b11, 16'($urandom)});
    emit(1'b1);
    n = 0;
    while (pulses < exp_unders && n < 200) begin
      @(posedge gmii_tx_clk); #1;
      n++;
    end
    chk("underrun_seen", pulses, exp_unders);
    chk("underrun_count", tx_underrun_count, exp_unders);
    push_word({2'b11, 16'hDEAD});
    push_word({2'b00, 16'hBEEF});
    push_frame4();
    wait_idle("underrun");

    // Randomized batches; the first also drops tx_enable mid-frame.
    for (int b = 0; b < 3; b++) begin
      tx_enable = 1'b0;
      nf = $urandom_range(4, 8);
      for (int f = 0; f < nf; f++) gen_frame(f == nf - 1);
      tx_enable = 1'b1;
      if (b == 0) begin
        n = 0;
        while (!bus.gmii_tx_en && n < 50) begin
          @(posedge gmii_tx_clk); #1;
          n++;
        end
        chk("rand_start", bus.gmii_tx_en, 1);
        fc0 = longint'(tx_frame_count);
        tx_enable = 1'b0;
        repeat (200) @(posedge gmii_tx_clk);
        #1;
        chk("disable_one_frame", tx_frame_count, fc0 + 1);
        chk("disable_idle", busy, 0);
        tx_enable = 1'b1;
      end
      wait_idle("random");
    end

    // Reset in the middle of the payload.
    for (int i = 0; i < 5; i++) push_word({2'b11, 16'($urandom)});
    push_word({2'b00, 16'h0000});
    n = 0;
    while (!bus.gmii_tx_en && n < 50) begin
      @(posedge gmii_tx_clk); #1;
      n++;
    end
    repeat (11) @(posedge gmii_tx_clk);
    #1;
    chk("pre_reset_active", bus.gmii_tx_en, 1);
    sys_rst = 1'b1;
    fifo_q.delete();
    pend.delete();
    exp_q.delete();
    discarding = 1'b0;
    exp_frames = 0;
    exp_unders = 0;
    chk("rst_mid_rd_en", bus.rd_en, 0);
    @(posedge gmii_tx_clk); #1;
    chk("rst_mid_tx_en", bus.gmii_tx_en, 0);
    chk("rst_mid_txd", bus.gmii_txd, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frames", tx_frame_count, 0);
    chk("rst_mid_unders", tx_underrun_count, 0);
    sys_rst = 1'b0;
    @(posedge gmii_tx_clk); #1;
    push_frame4();
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
